// File: rtl/ip_table_access_ctrl.sv
// ip_table_access_ctrl
//   Initiator side of the destination-IP table req/ack port. Accepts one register-level
//   command at a time (read, write, clear-all), issues single-cycle requests to the
//   lookup-stage table, waits for the matching ack with a timeout, and returns one
//   response per command.
//
// Ports
//   AXI_ACLK, reset        clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; cmd_op 00 rd, 01 wr, 10 clear-all, 11 reserved
//   cmd_addr, cmd_wdata    entry address and write data
//   rsp_valid/rsp_ready    response handshake; rsp_status 00 OK, 01 TIMEOUT, 10 BAD_ADDR,
//                          11 BAD_OP; rsp_rdata is read data (0 unless a read succeeded)
//   tbl_rd_req/tbl_wr_req  one-cycle requests to the table
//   tbl_rd_addr/_wr_addr   request address (held until the access completes)
//   tbl_wr_data            write data (0 during clear-all)
//   tbl_rd_data/_rd_ack    read data qualified by the read ack
//   tbl_wr_ack             write ack
//   timeout_count          saturating count of accesses that timed out
module ip_table_access_ctrl #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned TBL_ADDR_WIDTH     = 5,
    parameter int unsigned TBL_DEPTH          = 32,
    parameter int unsigned TIMEOUT            = 16
) (
    input  logic                          AXI_ACLK,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [1:0]                    rsp_status,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                          tbl_rd_req,
    output logic                          tbl_wr_req,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
    output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
    input  logic                          tbl_rd_ack,
    input  logic                          tbl_wr_ack,
    output logic [31:0]                   timeout_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    localparam logic [1:0] RSP_OK       = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT  = 2'd1;
    localparam logic [1:0] RSP_BAD_ADDR = 2'd2;
    localparam logic [1:0] RSP_BAD_OP   = 2'd3;

    localparam logic [7:0]                TIMEOUT_LOAD = 8'(TIMEOUT);
    localparam logic [TBL_ADDR_WIDTH-1:0] LAST_ADDR    = TBL_ADDR_WIDTH'(TBL_DEPTH - 1);
    localparam logic [TBL_ADDR_WIDTH-1:0] ADDR_ONE     = TBL_ADDR_WIDTH'(1);

    logic [1:0]                    state_q, state_d;
    logic [1:0]                    op_q, op_d;
    logic [TBL_ADDR_WIDTH-1:0]     addr_q, addr_d;    // also the clear-all cursor
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]                    wait_cnt_q, wait_cnt_d;
    logic                          rd_req_q, rd_req_d;
    logic                          wr_req_q, wr_req_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [1:0]                    status_q, status_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]                   tmo_cnt_q, tmo_cnt_d;

    logic cmd_fire;
    logic addr_oob;
    logic ack_hit;

    // cmd_ready is also masked by reset so nothing is accepted while reset is applied.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign addr_oob  = 32'(cmd_addr) >= TBL_DEPTH;
    // Only the ack type matching the outstanding request completes it.
    assign ack_hit   = (op_q == OP_READ) ? tbl_rd_ack : tbl_wr_ack;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        rsp_valid_d = rsp_valid_q;
        status_d    = status_q;
        rdata_d     = rdata_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = (cmd_op == OP_WRITE) ? cmd_wdata : '0;
                    if (cmd_op == OP_RSVD) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        status_d    = RSP_BAD_OP;
                    end else if (cmd_op == OP_CLEAR) begin
                        addr_d   = '0;
                        state_d  = ST_ISSUE;
                        wr_req_d = 1'b1;
                    end else if (addr_oob) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        status_d    = RSP_BAD_ADDR;
                    end else begin
                        state_d  = ST_ISSUE;
                        rd_req_d = (cmd_op == OP_READ);
                        wr_req_d = (cmd_op == OP_WRITE);
                    end
                end
            end
            ST_ISSUE: begin
                // Request was raised on entry; it drops now, after exactly one cycle.
                state_d    = ST_WAIT;
                wait_cnt_d = TIMEOUT_LOAD;
            end
            ST_WAIT: begin
                // Ack is checked before expiry so an ack in the last cycle still wins.
                if (ack_hit) begin
                    if (op_q == OP_READ) begin
                        rdata_d = tbl_rd_data;
                    end
                    if ((op_q == OP_CLEAR) && (addr_q < LAST_ADDR)) begin
                        addr_d   = addr_q + ADDR_ONE;
                        state_d  = ST_ISSUE;
                        wr_req_d = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        status_d    = RSP_OK;
                    end
                end else if (wait_cnt_q <= 8'd1) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    status_d    = RSP_TIMEOUT;
                    if (tmo_cnt_q != '1) begin
                        tmo_cnt_d = tmo_cnt_q + 32'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    status_d    = RSP_OK;
                    rdata_d     = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= RSP_OK;
            rdata_q     <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            rsp_valid_q <= rsp_valid_d;
            status_q    <= status_d;
            rdata_q     <= rdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = status_q;
    assign rsp_rdata     = rdata_q;
    assign tbl_rd_req    = rd_req_q;
    assign tbl_wr_req    = wr_req_q;
    assign tbl_rd_addr   = addr_q;
    assign tbl_wr_addr   = addr_q;
    assign tbl_wr_data   = wdata_q;
    assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_ip_table_access_ctrl.sv
// tb_ip_table_access_ctrl
//   Directed bench: a vector table of complete commands against a 1-cycle-ack responder
//   model, plus hand-written sequences for timeout, ack-at-expiry, late and wrong-type
//   acks, reset during clear-all, and BAD_ADDR on a shallower table instance.
module tb_ip_table_access_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic        tbl_rd_req, tbl_wr_req;
    logic [4:0]  tbl_rd_addr, tbl_wr_addr;
    logic [31:0] tbl_wr_data, tbl_rd_data;
    logic        tbl_rd_ack, tbl_wr_ack;
    logic [31:0] timeout_count;

    // Responder-model drive and main-process injection are kept separate, then OR-ed.
    logic        resp_rd_ack, resp_wr_ack, inj_rd_ack, inj_wr_ack, resp_en;
    logic [31:0] resp_rd_data, inj_rd_data;
    assign tbl_rd_ack  = resp_rd_ack | inj_rd_ack;
    assign tbl_wr_ack  = resp_wr_ack | inj_wr_ack;
    assign tbl_rd_data = resp_rd_data | inj_rd_data;

    // Second instance: 20-entry table, short timeout, no responder.
    logic        c2_valid, c2_ready, r2_valid, r2_ready, t2_rd_req, t2_wr_req;
    logic        t2_rd_ack, t2_wr_ack;
    logic [1:0]  c2_op, r2_status;
    logic [4:0]  c2_addr, t2_rd_addr, t2_wr_addr;
    logic [31:0] c2_wdata, r2_rdata, t2_wr_data, t2_rd_data, t2_tocnt;

    ip_table_access_ctrl u_dut (
        .AXI_ACLK(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_rdata(rsp_rdata),
        .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req), .tbl_rd_addr(tbl_rd_addr),
        .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
        .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack), .timeout_count(timeout_count)
    );

    ip_table_access_ctrl #(.TBL_DEPTH(20), .TIMEOUT(4)) u_dut20 (
        .AXI_ACLK(clk), .reset(reset),
        .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_op(c2_op),
        .cmd_addr(c2_addr), .cmd_wdata(c2_wdata),
        .rsp_valid(r2_valid), .rsp_ready(r2_ready), .rsp_status(r2_status),
        .rsp_rdata(r2_rdata),
        .tbl_rd_req(t2_rd_req), .tbl_wr_req(t2_wr_req), .tbl_rd_addr(t2_rd_addr),
        .tbl_wr_addr(t2_wr_addr), .tbl_wr_data(t2_wr_data), .tbl_rd_data(t2_rd_data),
        .tbl_rd_ack(t2_rd_ack), .tbl_wr_ack(t2_wr_ack), .timeout_count(t2_tocnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Responder model + monitor: samples at negedge, acks one cycle after the request.
    logic [31:0] mem [32];
    logic [36:0] wr_log [$];
    int          wr_pulses = 0, rd_pulses = 0, rsp_rise = 0, b2b = 0;
    initial begin
        logic       rd_seen, wr_seen, prev_rd, prev_wr, prev_rsp;
        logic [4:0] raddr;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        resp_rd_ack = 1'b0; resp_wr_ack = 1'b0; resp_rd_data = 32'd0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_rsp = 1'b0;
        forever begin
            @(negedge clk);
            rd_seen = tbl_rd_req && resp_en;
            wr_seen = tbl_wr_req && resp_en;
            raddr   = tbl_rd_addr;
            if (tbl_wr_req) begin
                wr_log.push_back({tbl_wr_addr, tbl_wr_data});
                wr_pulses++;
            end
            if (tbl_rd_req) rd_pulses++;
            if ((tbl_rd_req && prev_rd) || (tbl_wr_req && prev_wr)) b2b++;
            if (rsp_valid && !prev_rsp) rsp_rise++;
            prev_rd = tbl_rd_req; prev_wr = tbl_wr_req; prev_rsp = rsp_valid;
            if (wr_seen) mem[tbl_wr_addr] = tbl_wr_data;
            @(posedge clk); #1;
            resp_rd_ack  = rd_seen;
            resp_wr_ack  = wr_seen;
            resp_rd_data = rd_seen ? mem[raddr] : 32'd0;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Returns #1 after the handshake edge (cycle T+1).
    task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 5'd0; cmd_wdata = 32'd0;
    endtask

    task automatic release_rsp();
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd,
                           input int hold, output logic [1:0] st, output logic [31:0] rd,
                           output int lat, output int nwr, output int nrd, output int nrsp,
                           output logic stable, output logic released);
        int wr0, rd0, rsp0;
        wr0 = wr_pulses; rd0 = rd_pulses; rsp0 = rsp_rise;
        issue(op, addr, wd);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        st = rsp_status; rd = rsp_rdata; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_status !== st || rsp_rdata !== rd || cmd_ready) stable = 1'b0;
        end
        release_rsp();
        released = !rsp_valid && (rsp_rdata == 32'd0) && cmd_ready;
        nwr = wr_pulses - wr0; nrd = rd_pulses - rd0; nrsp = rsp_rise - rsp0;
    endtask

    task automatic run2(input logic [4:0] addr, output logic [1:0] st, output int lat,
                        output int nreq);
        @(posedge clk); #1;
        c2_valid = 1'b1; c2_op = 2'd0; c2_addr = addr;
        @(negedge clk);
        @(posedge clk); #1;
        c2_valid = 1'b0;
        lat = 0; nreq = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (t2_rd_req) nreq++;
            if (r2_valid) break;
        end
        st = r2_status;
        @(posedge clk); #1; r2_ready = 1'b1;
        @(posedge clk); #1; r2_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic [1:0]  st;
        logic [31:0] rdata;
        int          lat;
        int          nwr;
        int          nrd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [1:0]  st;
        logic [31:0] rd;
        logic        stable, released, quiet;
        int          lat, nwr, nrd, nrsp, rsp0, wr0, logsz, bad;

        vecs[0] = '{2'd1, 5'd3,  32'h0A000001, 0, 2'd0, 32'h0,        3,  1,  0};
        vecs[1] = '{2'd0, 5'd3,  32'h0,        5, 2'd0, 32'h0A000001, 3,  0,  1};
        vecs[2] = '{2'd1, 5'd31, 32'hDEADBEEF, 1, 2'd0, 32'h0,        3,  1,  0};
        vecs[3] = '{2'd0, 5'd31, 32'h0,        0, 2'd0, 32'hDEADBEEF, 3,  0,  1};
        vecs[4] = '{2'd3, 5'd7,  32'h00001234, 2, 2'd3, 32'h0,        1,  0,  0};
        vecs[5] = '{2'd2, 5'd9,  32'hFFFFFFFF, 0, 2'd0, 32'h0,        65, 32, 0};
        vecs[6] = '{2'd0, 5'd3,  32'h0,        0, 2'd0, 32'h0,        3,  0,  1};
        vecs[7] = '{2'd0, 5'd31, 32'h0,        0, 2'd0, 32'h0,        3,  0,  1};
        vecs[8] = '{2'd1, 5'd0,  32'h12345678, 0, 2'd0, 32'h0,        3,  1,  0};
        vecs[9] = '{2'd0, 5'd0,  32'h0,        0, 2'd0, 32'h12345678, 3,  0,  1};

        reset = 1'b1; resp_en = 1'b1; inj_rd_ack = 1'b0; inj_wr_ack = 1'b0; inj_rd_data = 0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 5'd0; cmd_wdata = 32'd0; rsp_ready = 1'b0;
        c2_valid = 1'b0; c2_op = 2'd0; c2_addr = 5'd0; c2_wdata = 32'd0; r2_ready = 1'b0;
        t2_rd_ack = 1'b0; t2_wr_ack = 1'b0; t2_rd_data = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset cmd_ready", cmd_ready, 0);
        check("reset outputs", {rsp_valid, rsp_status, rsp_rdata, tbl_rd_req, tbl_wr_req}, 0);
        check("reset tbl addr/data", {tbl_rd_addr, tbl_wr_addr, tbl_wr_data}, 0);
        check("reset timeout_count", timeout_count, 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        check("idle cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            logsz = wr_log.size();
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                    st, rd, lat, nwr, nrd, nrsp, stable, released);
            check($sformatf("v%0d status", i), st, vecs[i].st);
            check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d wr_req pulses", i), nwr, vecs[i].nwr);
            check($sformatf("v%0d rd_req pulses", i), nrd, vecs[i].nrd);
            check($sformatf("v%0d rsp count", i), nrsp, 1);
            check($sformatf("v%0d held stable", i), stable, 1);
            check($sformatf("v%0d released", i), released, 1);
            if (vecs[i].op == 2'd1 && wr_log.size() > 0)
                check($sformatf("v%0d wr addr/data", i), wr_log[wr_log.size() - 1],
                      {vecs[i].addr, vecs[i].wdata});
            if (vecs[i].op == 2'd2) begin
                bad = 0;
                for (int j = 0; j < 32; j++) begin
                    if (logsz + j >= wr_log.size()) bad++;
                    else if (wr_log[logsz + j] !== {5'(j), 32'd0}) bad++;
                end
                check("clear-all addr sequence/data", bad, 0);
            end
        end

        // Timeout: no responder, 16 WAIT cycles then TIMEOUT.
        resp_en = 1'b0;
        run_cmd(2'd0, 5'd0, 32'd0, 0, st, rd, lat, nwr, nrd, nrsp, stable, released);
        check("timeout status", st, 1);
        check("timeout latency", lat, 18);
        check("timeout rdata", rd, 0);
        check("timeout_count after timeout", timeout_count, 1);

        // Late ack after the timed-out access is ignored.
        rsp0 = rsp_rise;
        @(posedge clk); #1;
        @(posedge clk); #1; inj_rd_ack = 1'b1; inj_rd_data = 32'hBAD0BAD0;
        @(posedge clk); #1; inj_rd_ack = 1'b0; inj_rd_data = 32'd0;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || !cmd_ready) quiet = 1'b0;
        end
        @(posedge clk); #1;
        check("late ack no rsp", quiet, 1);
        check("late ack rsp count", rsp_rise - rsp0, 0);
        check("late ack timeout_count", timeout_count, 1);

        // Ack in the final WAIT cycle wins over expiry.
        rsp0 = rsp_rise;
        issue(2'd0, 5'd7, 32'd0);
        repeat (16) @(posedge clk);
        #1; inj_rd_ack = 1'b1; inj_rd_data = 32'h55AA55AA;
        @(posedge clk); #1; inj_rd_ack = 1'b0; inj_rd_data = 32'd0;
        @(negedge clk);
        check("expiry-ack rsp_valid", rsp_valid, 1);
        check("expiry-ack status", rsp_status, 0);
        check("expiry-ack rdata", rsp_rdata, 32'h55AA55AA);
        check("expiry-ack timeout_count", timeout_count, 1);
        release_rsp();
        check("expiry-ack rsp count", rsp_rise - rsp0, 1);

        // Wrong-type ack during a read WAIT is ignored; the read ack then completes it.
        issue(2'd0, 5'd5, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; inj_wr_ack = 1'b1;
        @(posedge clk); #1; inj_wr_ack = 1'b0;
        @(negedge clk);
        check("wrong ack ignored", rsp_valid, 0);
        @(posedge clk); #1; inj_rd_ack = 1'b1; inj_rd_data = 32'h00000077;
        @(posedge clk); #1; inj_rd_ack = 1'b0; inj_rd_data = 32'd0;
        @(negedge clk);
        check("read ack after wrong ack", {rsp_valid, rsp_status, rsp_rdata}, {3'b100, 32'h77});
        release_rsp();

        // Reset during clear-all at entry 10: access aborted, no response.
        resp_en = 1'b1;
        wr0 = wr_pulses; rsp0 = rsp_rise;
        issue(2'd2, 5'd0, 32'd0);
        repeat (20) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        check("clear at addr 10", {tbl_wr_req, tbl_wr_addr}, {1'b1, 5'd10});
        @(posedge clk); #1;
        check("reset mid-clear reqs low", {tbl_wr_req, tbl_rd_req, rsp_valid}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("reset mid-clear idle", {cmd_ready, tbl_wr_req}, 2'b10);
        repeat (6) @(posedge clk);
        #1;
        check("reset mid-clear wr pulses", wr_pulses - wr0, 11);
        check("reset mid-clear no rsp", rsp_rise - rsp0, 0);
        check("reset clears timeout_count", timeout_count, 0);

        // Shallow table: BAD_ADDR at and above depth, in-range access times out after 4.
        run2(5'd25, st, lat, nrd);
        check("depth20 addr25 status", st, 2);
        check("depth20 addr25 no req", {lat, nrd}, {32'd1, 32'd0});
        run2(5'd20, st, lat, nrd);
        check("depth20 addr20 status", st, 2);
        run2(5'd19, st, lat, nrd);
        check("depth20 addr19 timeout", st, 1);
        check("depth20 addr19 latency/reqs", {lat, nrd}, {32'd6, 32'd1});
        check("depth20 timeout_count", t2_tocnt, 1);

        check("no back-to-back req", b2b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
